// File: rtl/axi4_wr_burst_scheduler_pkg.sv
// Shared types and helpers for the AXI4 write burst scheduler.
package axi4_sched_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        AW,
        W,
        DRAIN
    } sched_state_e;

    // Beats in the next burst: limited by what is left, the burst cap and the distance to the 4KB page end.
    function automatic logic [8:0] burst_len(
        input logic [11:0] addr_lo,
        input int unsigned remaining,
        input int unsigned max_burst,
        input int unsigned addr_step
    );
        int unsigned lim;
        lim = (32'd4096 - 32'(addr_lo)) / addr_step;
        if (max_burst < lim) lim = max_burst;
        if (remaining < lim) lim = remaining;
        return 9'(lim);
    endfunction

endpackage

// File: rtl/axi4_wr_burst_scheduler_if.sv
// Command, data-stream and AXI4 write-channel bundle for the burst scheduler.
interface axi4_wr_burst_scheduler_if #(
    parameter int unsigned DSIZE  = 64,
    parameter int unsigned ASIZE  = 32,
    parameter int unsigned IDSIZE = 4,
    parameter int unsigned CLSIZE = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ASIZE-1:0]     cmd_addr;
    logic [CLSIZE-1:0]    cmd_len;

    logic                 s_tvalid;
    logic                 s_tready;
    logic [DSIZE-1:0]     s_tdata;

    logic                 axi_awvalid;
    logic                 axi_awready;
    logic [ASIZE-1:0]     axi_awaddr;
    logic [7:0]           axi_awlen;
    logic [2:0]           axi_awsize;
    logic [1:0]           axi_awburst;
    logic [IDSIZE-1:0]    axi_awid;

    logic                 axi_wvalid;
    logic                 axi_wready;
    logic [DSIZE-1:0]     axi_wdata;
    logic [DSIZE/8-1:0]   axi_wstrb;
    logic                 axi_wlast;

    logic                 axi_bvalid;
    logic                 axi_bready;
    logic [1:0]           axi_bresp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        input  s_tvalid, s_tdata,
        output s_tready,
        output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp,
        output axi_bready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        output s_tvalid, s_tdata,
        input  s_tready,
        input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp,
        input  axi_bready
    );

endinterface

// File: rtl/axi4_wr_burst_scheduler_outst.sv
// Saturating up/down count of AW handshakes still waiting for their B response.
module axi4_outstanding_cnt #(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          up, down;

    assign full  = (cnt_q == CW'(MAX_OUTST));
    assign empty = (cnt_q == '0);
    assign up    = inc && !full;
    assign down  = dec && !empty;

    always_comb begin
        cnt_d = cnt_q;
        if (up && !down)      cnt_d = cnt_q + CW'(1);
        else if (down && !up) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axi4_wr_burst_scheduler.sv
// Splits {addr,len} write commands into 4KB-safe AXI4 INCR bursts, gates the
// data stream onto W and tracks B responses under an outstanding limit.
module axi4_wr_burst_scheduler
    import axi4_sched_pkg::*;
#(
    parameter int unsigned DSIZE     = 64,
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned CLSIZE    = 16,
    parameter int unsigned MAX_BURST = 256,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    axi4_wr_burst_scheduler_if.master bus,
    output logic                      done,
    output logic                      err
);
    localparam int unsigned ADDR_STEP = DSIZE / 8;
    localparam int unsigned STEP_LOG2 = $clog2(ADDR_STEP);

    sched_state_e      state_q, state_d;
    logic [ASIZE-1:0]  addr_q, addr_d;
    logic [CLSIZE-1:0] rem_q, rem_d;
    logic [8:0]        blen_q, blen_d;
    logic [8:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              bready_q;

    logic outst_full, outst_empty;
    logic in_w, awvalid, wlast;
    logic cmd_hs, aw_hs, w_hs, b_hs, b_counted;

    assign in_w      = (state_q == W);
    assign awvalid   = (state_q == AW) && !outst_full;
    assign wlast     = in_w && (beat_q == blen_q - 9'd1);
    assign cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    assign aw_hs     = awvalid && bus.axi_awready;
    assign w_hs      = in_w && bus.s_tvalid && bus.axi_wready;
    assign b_hs      = bus.axi_bvalid && bready_q;
    // A B with nothing outstanding is dropped entirely, including its bresp.
    assign b_counted = b_hs && !outst_empty;

    assign bus.cmd_ready   = bready_q && (state_q == IDLE);
    assign bus.s_tready    = in_w && bus.axi_wready;
    assign bus.axi_awvalid = awvalid;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awlen   = 8'(blen_q - 9'd1);
    assign bus.axi_awsize  = 3'(STEP_LOG2);
    assign bus.axi_awburst = AXI_BURST_INCR;
    assign bus.axi_awid    = IDSIZE'(0);
    assign bus.axi_wvalid  = in_w && bus.s_tvalid;
    assign bus.axi_wdata   = bus.s_tdata;
    assign bus.axi_wstrb   = '1;
    assign bus.axi_wlast   = wlast;
    assign bus.axi_bready  = bready_q;
    assign done            = done_q;
    assign err             = err_q;

    axi4_outstanding_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst (
        .clk   (axi_aclk),
        .rst_n (axi_aresetn),
        .inc   (aw_hs),
        .dec   (b_counted),
        .full  (outst_full),
        .empty (outst_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        blen_d  = blen_q;
        beat_d  = beat_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (b_counted && (bus.axi_bresp != AXI_RESP_OKAY)) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d  = bus.cmd_addr & ~ASIZE'(ADDR_STEP - 1);
                    rem_d   = bus.cmd_len;
                    err_d   = 1'b0;
                    state_d = (bus.cmd_len == '0) ? DRAIN : CALC;
                end
            end
            CALC: begin
                blen_d  = burst_len(addr_q[11:0], 32'(rem_q), MAX_BURST, ADDR_STEP);
                state_d = AW;
            end
            AW: begin
                if (aw_hs) begin
                    addr_d  = addr_q + (ASIZE'(blen_q) << STEP_LOG2);
                    rem_d   = rem_q - CLSIZE'(blen_q);
                    beat_d  = '0;
                    state_d = W;
                end
            end
            W: begin
                if (w_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (wlast) state_d = (rem_q == '0) ? DRAIN : CALC;
                end
            end
            DRAIN: begin
                if (outst_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            blen_q   <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            bready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            blen_q   <= blen_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            done_q   <= done_d;
            bready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_wr_burst_scheduler.sv
// Directed, table-driven bench for axi4_wr_burst_scheduler with a small AXI slave model.
module tb_axi4_wr_burst_scheduler;

    typedef struct packed {
        logic [31:0]      addr;
        logic [15:0]      len;
        logic             slow;
        logic [2:0]       nb;
        logic [2:0][31:0] aw_addr;
        logic [2:0][7:0]  aw_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic done, err;

    always #5 clk = ~clk;

    axi4_wr_burst_scheduler_if #(.DSIZE(64), .ASIZE(32), .IDSIZE(4), .CLSIZE(16)) bus ();

    axi4_wr_burst_scheduler #(
        .DSIZE(64), .ASIZE(32), .IDSIZE(4), .CLSIZE(16), .MAX_BURST(256), .MAX_OUTST(4)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus),
        .done        (done),
        .err         (err)
    );

    // Observation state, written only by the monitor
    logic [31:0] obs_addr [128];
    logic [7:0]  obs_len  [128];
    int n_aw = 0, n_bdone = 0, beat_in_burst = 0, n_wlast_seen = 0, w_beats_tot = 0;
    int b_cnt_tot = 0, pending = 0, max_pend = 0, n_done = 0;
    int aw_unstable = 0, w_early = 0, wlast_bad = 0, wdata_bad = 0;
    logic err_at_done = 1'b0;
    logic prev_aw_wait = 1'b0;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;

    // Stimulus controls, written only by the main initial block
    logic aw_slow = 1'b0, w_slow = 1'b0, b_en = 1'b1;
    int   slverr_at = -1;
    int   n_checks = 0, n_fail = 0;
    int   base_aw, base_w, base_wl, base_done;
    int   phase = 0;
    vec_t vt [6];

    // Slave/source drivers update just after the rising edge
    always @(posedge clk) begin
        #1;
        phase++;
        bus.axi_awready = aw_slow ? phase[0] : 1'b1;
        bus.axi_wready  = w_slow ? ((phase % 3) != 0) : 1'b1;
        bus.s_tvalid    = 1'b1;
        bus.s_tdata     = {32'hC0DE0000, 32'(w_beats_tot)};
        bus.axi_bvalid  = b_en && (pending > 0);
        bus.axi_bresp   = (b_cnt_tot == slverr_at) ? 2'b10 : 2'b00;
    end

    // Monitor samples on the falling edge; handshakes seen here complete at the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            pending       = 0;
            n_bdone       = n_aw;
            beat_in_burst = 0;
            prev_aw_wait  = 1'b0;
        end else begin
            if (prev_aw_wait && (!bus.axi_awvalid || bus.axi_awaddr != prev_awaddr ||
                                 bus.axi_awlen != prev_awlen))
                aw_unstable++;
            prev_aw_wait = bus.axi_awvalid && !bus.axi_awready;
            prev_awaddr  = bus.axi_awaddr;
            prev_awlen   = bus.axi_awlen;
            if (bus.axi_wvalid && bus.axi_wready) begin
                if (n_bdone >= n_aw) begin
                    w_early++;
                end else begin
                    if (bus.axi_wlast != (beat_in_burst == int'(obs_len[n_bdone % 128])))
                        wlast_bad++;
                    if (beat_in_burst == int'(obs_len[n_bdone % 128])) begin
                        n_bdone++;
                        beat_in_burst = 0;
                    end else begin
                        beat_in_burst++;
                    end
                end
                if (bus.axi_wdata != {32'hC0DE0000, 32'(w_beats_tot)}) wdata_bad++;
                if (bus.axi_wlast) n_wlast_seen++;
                w_beats_tot++;
            end
            if (bus.axi_awvalid && bus.axi_awready) begin
                obs_addr[n_aw % 128] = bus.axi_awaddr;
                obs_len[n_aw % 128]  = bus.axi_awlen;
                n_aw++;
                pending++;
                if (pending > max_pend) max_pend = pending;
            end
            if (bus.axi_bvalid && bus.axi_bready) begin
                b_cnt_tot++;
                if (pending > 0) pending--;
            end
            if (done) begin
                n_done++;
                err_at_done = err;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk_vec(input logic [31:0] a, input logic [15:0] l, input logic s,
                                    input logic [2:0] nb,
                                    input logic [31:0] a0, input logic [7:0] l0,
                                    input logic [31:0] a1, input logic [7:0] l1,
                                    input logic [31:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = a; v.len = l; v.slow = s; v.nb = nb;
        v.aw_addr[0] = a0; v.aw_len[0] = l0;
        v.aw_addr[1] = a1; v.aw_len[1] = l1;
        v.aw_addr[2] = a2; v.aw_len[2] = l2;
        return v;
    endfunction

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] l);
        int k;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cmd_ready && k < 200);
        check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        base_aw = n_aw; base_w = w_beats_tot; base_wl = n_wlast_seen; base_done = n_done;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done == base_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(n_done > base_done), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        aw_slow = v.slow;
        w_slow  = v.slow;
        start_cmd(v.addr, v.len);
        wait_done(3000);
        check($sformatf("v%0d_aw_count", id), 64'(n_aw - base_aw), 64'(v.nb));
        for (int j = 0; j < int'(v.nb); j++) begin
            check($sformatf("v%0d_awaddr%0d", id, j), 64'(obs_addr[(base_aw + j) % 128]), 64'(v.aw_addr[j]));
            check($sformatf("v%0d_awlen%0d", id, j), 64'(obs_len[(base_aw + j) % 128]), 64'(v.aw_len[j]));
        end
        check($sformatf("v%0d_w_beats", id), 64'(w_beats_tot - base_w), 64'(v.len));
        check($sformatf("v%0d_wlast_count", id), 64'(n_wlast_seen - base_wl), 64'(v.nb));
        check($sformatf("v%0d_err_at_done", id), 64'(err_at_done), 64'd0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_pulses", id), 64'(n_done - base_done), 64'd1);
        aw_slow = 1'b0;
        w_slow  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hi;
        vt[0] = mk_vec(32'h0000_1000, 16'd16,  1'b0, 3'd1, 32'h1000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);
        vt[1] = mk_vec(32'h0000_0F80, 16'd64,  1'b1, 3'd2, 32'h0F80, 8'd15, 32'h1000, 8'd47, 32'h0, 8'd0);
        vt[2] = mk_vec(32'h0000_0000, 16'd600, 1'b0, 3'd3, 32'h0, 8'd255, 32'h800, 8'd255, 32'h1000, 8'd87);
        vt[3] = mk_vec(32'h0000_0FF8, 16'd3,   1'b1, 3'd2, 32'h0FF8, 8'd0, 32'h1000, 8'd1, 32'h0, 8'd0);
        vt[4] = mk_vec(32'h0000_2005, 16'd2,   1'b0, 3'd1, 32'h2000, 8'd1, 32'h0, 8'd0, 32'h0, 8'd0);
        vt[5] = mk_vec(32'hFFFF_FFF8, 16'd2,   1'b0, 3'd2, 32'hFFFF_FFF8, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_awvalid", 64'(bus.axi_awvalid), 64'd0);
        check("rst_wvalid", 64'(bus.axi_wvalid), 64'd0);
        check("rst_s_tready", 64'(bus.s_tready), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_bready", 64'(bus.axi_bready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("bready_after_rst", 64'(bus.axi_bready), 64'd1);
        check("static_aw_fields", 64'({bus.axi_awsize, bus.axi_awburst, bus.axi_awid}), 64'({3'd3, 2'b01, 4'd0}));
        check("wstrb", 64'(bus.axi_wstrb), 64'hFF);

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Accept-to-awvalid latency is two cycles
        start_cmd(32'h0000_3000, 16'd4);
        @(negedge clk);
        check("lat_awvalid_c1", 64'(bus.axi_awvalid), 64'd0);
        @(negedge clk);
        check("lat_awvalid_c2", 64'({bus.axi_awvalid, bus.axi_awaddr}), 64'({1'b1, 32'h3000}));
        wait_done(200);

        // Zero-length command: no traffic, done two cycles after accept
        start_cmd(32'h0000_4000, 16'd0);
        @(negedge clk);
        check("len0_no_early_done", 64'(done), 64'd0);
        @(negedge clk);
        check("len0_done", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("len0_no_traffic", 64'({32'(n_aw - base_aw), 32'(w_beats_tot - base_w)}), 64'd0);
        check("len0_done_pulses", 64'(n_done - base_done), 64'd1);

        // Outstanding limit: B withheld, exactly four bursts go out
        b_en = 1'b0;
        start_cmd(32'h0, 16'd2048);
        k = 0;
        while (!((n_aw - base_aw) == 4 && (w_beats_tot - base_w) == 1024) && k < 2500) begin
            @(negedge clk);
            k++;
        end
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.axi_awvalid) hi++;
        end
        check("full_aw_count", 64'(n_aw - base_aw), 64'd4);
        check("full_w_beats", 64'(w_beats_tot - base_w), 64'd1024);
        check("full_awvalid_cycles", 64'(hi), 64'd0);
        b_en = 1'b1;
        wait_done(4000);
        check("full_aw_total", 64'(n_aw - base_aw), 64'd8);
        check("full_w_total", 64'(w_beats_tot - base_w), 64'd2048);
        check("full_last_awaddr", 64'(obs_addr[(base_aw + 7) % 128]), 64'h3800);
        repeat (3) @(negedge clk);
        check("full_done_pulses", 64'(n_done - base_done), 64'd1);

        // SLVERR on the second B of a command
        slverr_at = b_cnt_tot + 1;
        start_cmd(32'h0, 16'd600);
        wait_done(3000);
        check("slverr_err_at_done", 64'(err_at_done), 64'd1);
        repeat (5) @(negedge clk);
        check("slverr_err_sticky", 64'(err), 64'd1);
        slverr_at = -1;
        start_cmd(32'h0000_5000, 16'd16);
        @(negedge clk);
        check("err_cleared_on_accept", 64'(err), 64'd0);
        wait_done(300);
        check("err_clean_cmd", 64'(err_at_done), 64'd0);

        // Asynchronous reset in the middle of a W burst
        start_cmd(32'h0, 16'd64);
        k = 0;
        while ((w_beats_tot - base_w) < 5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_w_reached", 64'(bus.axi_wvalid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valids", 64'({bus.axi_awvalid, bus.axi_wvalid, bus.s_tready, bus.cmd_ready}), 64'd0);
        check("async_rst_flags", 64'({done, err, bus.axi_bready}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'({bus.cmd_ready, bus.axi_awvalid, bus.axi_wvalid}), 64'b100);
        run_vec(vt[0], 6);

        check("aw_stable_while_stalled", 64'(aw_unstable), 64'd0);
        check("no_w_before_aw", 64'(w_early), 64'd0);
        check("wlast_position", 64'(wlast_bad), 64'd0);
        check("wdata_passthrough", 64'(wdata_bad), 64'd0);
        check("max_outstanding", 64'(max_pend), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
